// File: rtl/roberto_tx_serial.sv
// Purpose: asynchronous serial transmitter for 7-bit ASCII; LSB first, start bit, optional even parity, two stop bits.
// Latency: start bit on the line the cycle after the partida edge; pronto rises (FRAME_LEN*DIV + 1) edges after that edge.
// Backpressure: partida is a level request sampled only while idle; ocupado covers the frame; ROBERTO_TX_PARIDADE_EN enables parity.
`timescale 1ns/1ps

package roberto_tx_serial_pkg;
    typedef enum logic [3:0] {
        INICIAL     = 4'b0000,
        TRANSMISSAO = 4'b0001,
        FINAL_TX    = 4'b0010
    } estado_t;
endpackage

module roberto_tx_serial #(
    parameter int DIV = 434
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       partida,
    input  logic [6:0] dados,
    output logic       saida_serial,
    output logic       pronto,
    output logic       ocupado,
    output logic [3:0] db_estado
);
    import roberto_tx_serial_pkg::*;

    // Frame layout: start + 7 data + [parity] + 2 stop.
`ifdef ROBERTO_TX_PARIDADE_EN
    localparam int FRAME_LEN = 11;
`else
    localparam int FRAME_LEN = 10;
`endif
    // Shift register holds every bit after the start bit; the start bit is
    // driven directly when the frame is accepted.
    localparam int SH_W = FRAME_LEN - 1;
    localparam int TW   = $clog2(DIV);

    localparam logic [TW-1:0] TICK_MAX = TW'(DIV - 1);
    localparam logic [3:0]    BITS_FIM = 4'(FRAME_LEN);

    estado_t         estado;
    estado_t         estado_prox;
    logic [TW-1:0]   tick;
    logic [TW-1:0]   tick_prox;
    logic [3:0]      bit_cnt;
    logic [3:0]      bit_cnt_prox;
    logic [SH_W-1:0] shreg;
    logic [SH_W-1:0] shreg_prox;
    logic            saida_prox;
    logic [SH_W-1:0] quadro;

    // Bits following the start bit, LSB first; ones fill the stop positions.
`ifdef ROBERTO_TX_PARIDADE_EN
    assign quadro = {2'b11, ^dados, dados};
`else
    assign quadro = {2'b11, dados};
`endif

    // State, counters, shift register and line driver; reset forces an idle line at once.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado       <= INICIAL;
            tick         <= '0;
            bit_cnt      <= '0;
            shreg        <= '1;
            saida_serial <= 1'b1;
        end else begin
            estado       <= estado_prox;
            tick         <= tick_prox;
            bit_cnt      <= bit_cnt_prox;
            shreg        <= shreg_prox;
            saida_serial <= saida_prox;
        end
    end

    // Next-state and datapath updates.
    // bit_cnt counts completed bits; once it reaches FRAME_LEN the last stop
    // bit has been held DIV cycles and the frame closes on the following edge.
    always_comb begin
        estado_prox  = estado;
        tick_prox    = tick;
        bit_cnt_prox = bit_cnt;
        shreg_prox   = shreg;
        saida_prox   = 1'b1;
        case (estado)
            INICIAL: begin
                if (partida) begin
                    estado_prox  = TRANSMISSAO;
                    tick_prox    = '0;
                    bit_cnt_prox = '0;
                    shreg_prox   = quadro;
                    saida_prox   = 1'b0;
                end
            end
            TRANSMISSAO: begin
                saida_prox = saida_serial;
                if (bit_cnt == BITS_FIM) begin
                    estado_prox = FINAL_TX;
                    saida_prox  = 1'b1;
                end else if (tick == TICK_MAX) begin
                    tick_prox    = '0;
                    bit_cnt_prox = bit_cnt + 4'd1;
                    saida_prox   = shreg[0];
                    shreg_prox   = {1'b1, shreg[SH_W-1:1]};
                end else begin
                    tick_prox = tick + 1'b1;
                end
            end
            FINAL_TX: begin
                estado_prox = INICIAL;
            end
            default: begin
                estado_prox = INICIAL;
            end
        endcase
    end

    // Status outputs decoded from the state register; unknown codes read as 1111.
    always_comb begin
        pronto    = 1'b0;
        ocupado   = 1'b0;
        db_estado = 4'b1111;
        case (estado)
            INICIAL: begin
                db_estado = 4'b0000;
            end
            TRANSMISSAO: begin
                ocupado   = 1'b1;
                db_estado = 4'b0001;
            end
            FINAL_TX: begin
                ocupado   = 1'b1;
                pronto    = 1'b1;
                db_estado = 4'b0010;
            end
            default: begin
                db_estado = 4'b1111;
            end
        endcase
    end

endmodule

// File: doc/roberto_tx_serial.md
ROBERTO_TX_SERIAL -- requirements
Module: roberto_tx_serial

Interface
REQ-001 SHALL have parameter: DIV, 434, clock cycles per serial bit (115200 baud at 50 MHz); legal range 2..4095.
REQ-002 SHALL have port: clock  input  1  single system clock; all state changes on its rising edge.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: partida  input  1  level request to start one frame; driven by roberto_uc partida_tx.
REQ-005 SHALL have port: dados  input  7  ASCII character to transmit; sampled only on frame start.
REQ-006 SHALL have port: saida_serial  output  1  serial line, idle high, registered.
REQ-007 SHALL have port: pronto  output  1  one-cycle pulse at frame end; drives roberto_uc pronto_serial.
REQ-008 SHALL have port: ocupado  output  1  high from frame start through the pronto cycle.
REQ-009 SHALL have port: db_estado  output  4  debug state code.

Function
REQ-010 SHALL implement FSM states: inicial (0000), transmissao (0001), final_tx (0010); any other code returns to inicial on the next edge and shows db_estado 1111.
REQ-011 SHALL, in inicial with partida=1 at a rising edge, latch dados, load the frame shift register, clear tick and bit counters, and enter transmissao on that edge.
REQ-012 SHALL ignore partida in transmissao and final_tx; dados changes after the start edge SHALL NOT affect the frame.
REQ-013 SHALL send frame LSB-first: start bit 0, dados[0]..dados[6], optional parity (see Configuration), two stop bits 1.
REQ-014 SHALL drive each frame bit on saida_serial for exactly DIV clock cycles; the start bit SHALL appear in the cycle right after the start edge.
REQ-015 SHALL use a tick counter 0..DIV-1 wrapping to 0 and advancing the bit counter on wrap; the bit counter SHALL NOT exceed frame length.
REQ-016 SHALL enter final_tx after the last stop bit has been held DIV cycles; pronto=1 only in final_tx, then return to inicial on the next edge.
REQ-017 SHALL keep saida_serial=1 in inicial and final_tx.
REQ-018 SHALL start a new frame directly from inicial if partida is still high there (back-to-back frames separated by one idle-high cycle per final_tx and one per inicial sample).
REQ-019 SHALL set ocupado=1 in transmissao and final_tx, 0 in inicial.
REQ-020 SHALL size counters as ceil(log2(DIV)) and 4 bits respectively; no arithmetic overflow for legal DIV.

Reset
REQ-021 SHALL, while reset=1 (including mid-frame), force state inicial, saida_serial=1, pronto=0, ocupado=0, db_estado=0000, counters 0, immediately without waiting for clock.
REQ-022 SHALL resume only via a fresh partida after reset deasserts; an aborted frame SHALL never produce pronto.

Configuration
REQ-023 SHALL use macro ROBERTO_TX_PARIDADE_EN: defined -> even parity bit (XOR of dados[6:0]) inserted after dados[6], frame = 11 bits (11*DIV cycles).
REQ-024 SHALL, without ROBERTO_TX_PARIDADE_EN, omit parity: frame = 10 bits (10*DIV cycles); all other behaviour identical.

Verification
REQ-025 SHALL verify: DIV=4, PARIDADE_EN, dados=7'h41, partida pulse 1 cycle -> line 0,1,0,0,0,0,0,1,0(parity),1,1 each 4 cycles; pronto pulse once, 45 cycles after start edge.
REQ-026 SHALL verify: DIV=4, no macro, dados=7'h33 -> line 0,1,1,0,0,1,1,0,1,1 each 4 cycles; pronto 41 cycles after start edge.
REQ-027 SHALL verify: partida held high for 100 cycles, DIV=4, PARIDADE_EN -> two complete frames, two pronto pulses, start of frame 2 two cycles after pronto of frame 1.
REQ-028 SHALL verify: dados changed and partida re-pulsed mid-frame -> transmitted bits match originally latched value; single pronto.
REQ-029 SHALL verify: reset asserted during bit 5 -> saida_serial=1 and db_estado=0000 in same cycle, no pronto; next partida sends a full correct frame.
REQ-030 SHALL verify: state register forced to 0111 -> db_estado=1111, inicial next edge, saida_serial=1.
